dvp_tx: RTL and testbench

//  DVP (OV5640-style 8-bit parallel) transmitter: serialises an RGB565 pixel stream into Vsync/Href/Data

---
 rtl/dvp_pkg.sv | 22 ++
 rtl/dvp_timing_gen.sv | 37 +++
 rtl/dvp_tx.sv | 148 ++++++++++++++
 tb/tb_dvp_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP transmitter: FSM state codes, byte-phase codes, width helper.
package dvp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFP    = 3'd4;

  localparam logic [1:0] BP_NONE = 2'd0;
  localparam logic [1:0] BP_HI   = 2'd1;
  localparam logic [1:0] BP_LO   = 2'd2;

  // Bits needed to count 0..v-1, never less than one bit.
  function automatic int unsigned dvp_clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Horizontal/vertical counters for the DVP transmitter; v_cnt counts lines within the current FSM state.
module dvp_timing_gen #(
  parameter int unsigned LINE_CYC = 2816,
  parameter int unsigned H_W      = 12,
  parameter int unsigned V_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [V_W-1:0] last_line,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           eos_c
);

  logic eol_c;

  assign eol_c = (h_cnt == H_W'(LINE_CYC - 1));
  assign eos_c = eol_c && (v_cnt == last_line);

  // Counters sit at zero while idle so every frame starts at line 0, cycle 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (eol_c) begin
      h_cnt <= '0;
      v_cnt <= eos_c ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter: serialises RGB565 pixels into Vsync/Href/Data byte timing, high byte first.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned H_BLANK     = 256,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned VSYNC_LINES = 4,
  parameter int unsigned VBP_LINES   = 16,
  parameter int unsigned VFP_LINES   = 4,
  parameter bit          VSYNC_POL   = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Enable,
  input  logic [15:0] Pix_Data,
  input  logic        Pix_Valid,
  output logic        Pix_Ready,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic        Frame_Start,
  output logic        Underrun,
  output logic        Busy
);

  localparam int unsigned LINE_CYC  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int unsigned MAX_B     = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned H_W       = dvp_clog2(LINE_CYC);
  localparam int unsigned V_W       = dvp_clog2(MAX_LINES);

  localparam logic [V_W-1:0] VS_LAST  = V_W'(VSYNC_LINES - 1);
  localparam logic [V_W-1:0] VBP_LAST = V_W'(VBP_LINES - 1);
  localparam logic [V_W-1:0] VA_LAST  = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] VFP_LAST = V_W'(VFP_LINES - 1);

  logic [2:0]     state, state_d;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt, last_line;
  logic           eos_c, run;
  logic           vs_d, fs_d, busy_d, href_d;
  logic [1:0]     phase_d;
  logic           s1_vs, s1_fs, s1_busy, s1_href, s1_lo;
  logic [7:0]     lo_q;

  assign run = (state != ST_IDLE);

  dvp_timing_gen #(
    .LINE_CYC (LINE_CYC),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_timing (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .run       (run),
    .last_line (last_line),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .eos_c     (eos_c)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state plus per-cycle decode of the counter position.
  always_comb begin
    state_d   = state;
    last_line = VS_LAST;
    vs_d      = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    href_d    = 1'b0;
    phase_d   = BP_NONE;
    case (state)
      ST_IDLE: begin
        if (Enable) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        last_line = VS_LAST;
        vs_d      = 1'b1;
        fs_d      = (h_cnt == '0) && (v_cnt == '0);
        busy_d    = 1'b1;
        if (eos_c) state_d = ST_VBP;
      end
      ST_VBP: begin
        last_line = VBP_LAST;
        busy_d    = 1'b1;
        if (eos_c) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        last_line = VA_LAST;
        busy_d    = 1'b1;
        href_d    = (h_cnt < H_W'(2 * H_ACTIVE));
        if (eos_c) state_d = ST_VFP;
      end
      ST_VFP: begin
        last_line = VFP_LAST;
        busy_d    = 1'b1;
        if (eos_c) state_d = Enable ? ST_VSYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (href_d) phase_d = h_cnt[0] ? BP_LO : BP_HI;
  end

  // Two-stage output pipe: Pix_Ready leads the high byte on Data/Href by one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_vs       <= 1'b0;
      s1_fs       <= 1'b0;
      s1_busy     <= 1'b0;
      s1_href     <= 1'b0;
      s1_lo       <= 1'b0;
      lo_q        <= 8'h00;
      Pix_Ready   <= 1'b0;
      Vsync       <= ~VSYNC_POL;
      Href        <= 1'b0;
      Data        <= 8'h00;
      Frame_Start <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      s1_vs       <= vs_d;
      s1_fs       <= fs_d;
      s1_busy     <= busy_d;
      s1_href     <= href_d;
      s1_lo       <= (phase_d == BP_LO);
      Pix_Ready   <= (phase_d == BP_HI);
      Vsync       <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
      Href        <= s1_href;
      Frame_Start <= s1_fs;
      Busy        <= s1_busy;
      if (Pix_Ready) begin
        Data <= Pix_Valid ? Pix_Data[15:8] : 8'h00;
        lo_q <= Pix_Valid ? Pix_Data[7:0] : 8'h00;
      end else begin
        Data <= s1_lo ? lo_q : 8'h00;
      end
    end
  end

  // Flags the empty slot in the same cycle the source was offered it.
  assign Underrun = Pix_Ready & ~Pix_Valid;

endmodule

// File: tb/tb_dvp_tx.sv
// Bench for dvp_tx: frame-position reference model, randomized source, capture of a second (Vsync active-low) instance.
module tb_dvp_tx;

  localparam int HA    = 4;
  localparam int HB    = 3;
  localparam int VA    = 2;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VBP + VA + VFP);

  logic        clk, rst_n, enable, pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready, vsync, href, frame_start, underrun, busy;
  logic [7:0]  data;
  logic        pix_ready0, vsync0, href0, frame_start0, underrun0, busy0;
  logic [7:0]  data0;

  int n_pass = 0;
  int n_chk  = 0;
  int k = -1;
  int frame = 0;
  int slot = 0;
  int wait_cnt = 0;
  int cap_cnt = 0;
  bit cap_ph = 0;
  logic [7:0]  cap_hi;
  logic [15:0] cur_pix = 16'h0;
  logic [15:0] capq[$];

  dvp_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
    .VBP_LINES(VBP), .VFP_LINES(VFP), .VSYNC_POL(1'b1)
  ) u_dut (
    .Clk(clk), .Rst_n(rst_n), .Enable(enable), .Pix_Data(pix_data), .Pix_Valid(pix_valid),
    .Pix_Ready(pix_ready), .Vsync(vsync), .Href(href), .Data(data),
    .Frame_Start(frame_start), .Underrun(underrun), .Busy(busy)
  );

  dvp_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
    .VBP_LINES(VBP), .VFP_LINES(VFP), .VSYNC_POL(1'b0)
  ) u_dut0 (
    .Clk(clk), .Rst_n(rst_n), .Enable(enable), .Pix_Data(pix_data), .Pix_Valid(pix_valid),
    .Pix_Ready(pix_ready0), .Vsync(vsync0), .Href(href0), .Data(data0),
    .Frame_Start(frame_start0), .Underrun(underrun0), .Busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit act_line(input int ln);
    return (ln >= VS + VBP) && (ln < VS + VBP + VA);
  endfunction

  // One clock: check outputs against the frame-position model, then drive the source.
  task automatic step();
    int ln, hp, ln1, hp1;
    bit er, hr;
    logic v;
    logic [15:0] d, pix, ep;
    logic [7:0] ed;
    @(negedge clk);
    er = 1'b0;
    if (k < 0 && enable && rst_n && frame_start === 1'b1) begin
      k = 0;
      wait_cnt = 0;
    end
    if (k < 0) begin
      chk1("idle_vsync", vsync, 1'b0);
      chk1("idle_vsync0", vsync0, 1'b1);
      chk1("idle_href", href, 1'b0);
      chk16("idle_data", 16'(data), 16'h0);
      chk1("idle_ready", pix_ready, 1'b0);
      chk1("idle_ready0", pix_ready0, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_fstart", frame_start, 1'b0);
      if (enable && rst_n) begin
        wait_cnt++;
        if (wait_cnt == 6) chk1("start_timeout", frame_start, 1'b1);
      end
    end else begin
      ln  = k / LINE;
      hp  = k % LINE;
      ln1 = (k + 1) / LINE;
      hp1 = (k + 1) % LINE;
      hr  = act_line(ln) && hp < 2 * HA;
      er  = (k + 1 < FRAME) && act_line(ln1) && hp1 < 2 * HA && (hp1 % 2 == 0);
      ed  = hr ? ((hp % 2 == 0) ? cur_pix[15:8] : cur_pix[7:0]) : 8'h00;
      chk1("vsync", vsync, ln < VS);
      chk1("vsync0", vsync0, !(ln < VS));
      chk1("fstart", frame_start, k == 0);
      chk1("busy", busy, 1'b1);
      chk1("href", href, hr);
      chk16("data", 16'(data), 16'(ed));
      chk1("ready", pix_ready, er);
      chk1("ready0", pix_ready0, er);
    end
    if (href0 === 1'b1) begin
      if (!cap_ph) cap_hi = data0;
      else begin
        pix = {cap_hi, data0};
        ep  = (capq.size() > 0) ? capq.pop_front() : 16'hxxxx;
        chk16("cap_pix", pix, ep);
        cap_cnt++;
      end
      cap_ph = !cap_ph;
    end
    d = 16'($urandom);
    if (er) begin
      if (frame == 0) begin
        d = 16'h1234 + 16'(slot) * 16'h4444;
        v = 1'b1;
      end else if (frame == 1) v = (slot != 2);
      else v = ($urandom_range(0, 7) != 0);
      cur_pix = v ? d : 16'h0;
      capq.push_back(cur_pix);
      slot++;
    end else begin
      v = ($urandom_range(0, 3) == 0);
    end
    pix_valid = v;
    pix_data  = d;
    #1;
    chk1("underrun", underrun, er && !v);
    chk1("underrun0", underrun0, er && !v);
    if (k >= 0) begin
      if (k == FRAME - 1) chk16("pix_per_frame", 16'(cap_cnt), 16'(2 * HA));
      k++;
      if (k == FRAME) begin
        frame++;
        slot = 0;
        cap_cnt = 0;
        wait_cnt = 0;
        k = enable ? 0 : -1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    pix_valid = 1'b0;
    pix_data = 16'h0;
    repeat (4) step();
    rst_n = 1'b1;

    // Frames 0..2: fixed source, one dropped slot, random source.
    for (int i = 0; i < 400 && frame < 3; i++) step();

    // Drop Enable in the second active line; frame must still finish.
    for (int i = 0; i < 200 && !(frame == 3 && k == 35); i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && frame < 4; i++) step();
    repeat (20) step();

    // Restart, then asynchronous reset while Href is high.
    enable = 1'b1;
    for (int i = 0; i < 200 && !(frame == 4 && k == 27); i++) step();
    rst_n = 1'b0;
    #1;
    chk1("rst_href", href, 1'b0);
    chk16("rst_data", 16'(data), 16'h0);
    chk1("rst_ready", pix_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_vsync", vsync, 1'b0);
    chk1("rst_vsync0", vsync0, 1'b1);
    k = -1;
    slot = 0;
    cap_cnt = 0;
    cap_ph = 0;
    wait_cnt = 0;
    capq.delete();
    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 200 && !(frame == 5 && k == 10); i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && frame < 6; i++) step();
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
